// File: rtl/soc_mem_pkg.sv
// Shared types and helpers for the data-side memory slave.
package soc_mem_pkg;

    localparam int FLAG_WORD   = 0;
    localparam int RESULT_WORD = 1;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        RESP
    } mem_state_e;

    // Source of the response data, chosen at the grant edge.
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_FLAG,
        RD_RESULT,
        RD_RAM
    } rd_sel_e;

    function automatic logic [31:0] apply_be(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/soc_data_mem_if.sv
// req/gnt/rvalid data-port bundle between the core (master) and memory (slave).
interface soc_data_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [31:0]           data_wdata_i;
    logic [31:0]           data_rdata_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/soc_sram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables, no reset.
module soc_sram_be #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-first: rdata returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/soc_data_mem.sv
// Data-side memory slave: req/gnt/rvalid FSM, optional grant stall, RAM plus
// reset-able flag (word 0) and result (word 1) registers.
//
//   state | meaning
//   IDLE  | waiting for req; grants immediately when WAIT_CYCLES = 0
//   STALL | counting down the grant delay while req is held
//   RESP  | rvalid high for the granted access; may grant the next one (WAIT = 0)
module soc_data_mem
    import soc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    soc_data_mem_if.slave         bus,
    output logic                  done_o,
    output logic [31:0]           result_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              acc_wr;
    rd_sel_e           rd_sel_q;
    logic [31:0]       word0_q, word1_q;
    logic [31:0]       ram_rdata;
    logic              unused_addr_lsb;

    assign idx             = bus.data_addr_i[IDX_W+1:2];
    assign oor             = |bus.data_addr_i[ADDR_WIDTH-1:IDX_W+2];
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];
    assign acc_wr          = gnt && bus.data_we_i && !oor;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt     = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                // A dropped req here is a protocol violation; abandon quietly.
                if (!bus.data_req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (WAIT_CYCLES == 0 && bus.data_req_i) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rd_sel_q <= RD_ZERO;
            word0_q  <= 32'd0;
            word1_q  <= 32'd0;
            done_o   <= 1'b0;
            result_o <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc_wr && idx == IDX_W'(FLAG_WORD))
                word0_q <= apply_be(word0_q, bus.data_wdata_i, bus.data_be_i);
            if (acc_wr && idx == IDX_W'(RESULT_WORD))
                word1_q <= apply_be(word1_q, bus.data_wdata_i, bus.data_be_i);
            // Exported copies trail the word registers by one cycle.
            done_o   <= (word0_q != 32'd0);
            result_o <= word1_q;
            if (gnt && oor) err_o <= 1'b1;
            if (gnt) begin
                if (bus.data_we_i || oor)            rd_sel_q <= RD_ZERO;
                else if (idx == IDX_W'(FLAG_WORD))   rd_sel_q <= RD_FLAG;
                else if (idx == IDX_W'(RESULT_WORD)) rd_sel_q <= RD_RESULT;
                else                                 rd_sel_q <= RD_RAM;
            end
        end
    end

    soc_sram_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk_i),
        .en    (gnt && !oor),
        .we    (acc_wr),
        .be    (bus.data_be_i),
        .idx   (idx),
        .wdata (bus.data_wdata_i),
        .rdata (ram_rdata)
    );

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = (state_q == RESP);

    always_comb begin
        bus.data_rdata_o = 32'd0;
        if (state_q == RESP) begin
            case (rd_sel_q)
                RD_FLAG:   bus.data_rdata_o = word0_q;
                RD_RESULT: bus.data_rdata_o = word1_q;
                RD_RAM:    bus.data_rdata_o = ram_rdata;
                default:   bus.data_rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_data_mem.sv
// Directed bench for soc_data_mem: one instance with no stall, one with a 3-cycle stall.
module tb_soc_data_mem;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    soc_data_mem_if #(.ADDR_WIDTH(32)) bus0 ();
    soc_data_mem_if #(.ADDR_WIDTH(32)) bus3 ();

    logic        done0, err0, done3, err3;
    logic [31:0] result0, result3;

    soc_data_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_mem0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave),
        .done_o(done0), .result_o(result0), .err_o(err0)
    );

    soc_data_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_mem3 (
        .clk_i(clk), .rst_i(rst), .bus(bus3.slave),
        .done_o(done3), .result_o(result3), .err_o(err3)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic [31:0] addr,
                         input logic we, input logic [3:0] be, input logic [31:0] wdata);
        if (!sel) begin
            bus0.data_req_i = req; bus0.data_addr_i = addr; bus0.data_we_i = we;
            bus0.data_be_i = be;   bus0.data_wdata_i = wdata;
        end else begin
            bus3.data_req_i = req; bus3.data_addr_i = addr; bus3.data_we_i = we;
            bus3.data_be_i = be;   bus3.data_wdata_i = wdata;
        end
    endtask

    function automatic logic get_gnt(input bit sel);
        return sel ? bus3.data_gnt_o : bus0.data_gnt_o;
    endfunction

    function automatic logic get_rvalid(input bit sel);
        return sel ? bus3.data_rvalid_o : bus0.data_rvalid_o;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus3.data_rdata_o : bus0.data_rdata_o;
    endfunction

    // One transaction: lat = negedges from req rising to gnt seen (-1 on timeout).
    task automatic xact(input bit sel, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output int lat, output logic rv, output logic [31:0] rd);
        @(negedge clk);
        drive(sel, 1'b1, addr, we, be, wdata);
        #1;
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            if (get_gnt(sel)) begin
                lat = k;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, addr, we, be, wdata);
        @(negedge clk);
        rv = get_rvalid(sel);
        rd = get_rdata(sel);
    endtask

    function automatic vec_t mk(input bit sel, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.sel = sel; v.addr = addr; v.we = we; v.be = be; v.wdata = wdata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic        rv;
        logic [31:0] rd;
        int          hits;

        vecs.push_back(mk(0, 32'h10,   1, 4'hF, 32'hCAFEBABE, 32'h0));
        vecs.push_back(mk(0, 32'h10,   0, 4'hF, 32'h0,        32'hCAFEBABE));
        vecs.push_back(mk(0, 32'h14,   1, 4'hF, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk(0, 32'h14,   1, 4'h5, 32'h00000000, 32'h0));
        vecs.push_back(mk(0, 32'h14,   0, 4'hF, 32'h0,        32'hFF00FF00));
        vecs.push_back(mk(0, 32'h18,   1, 4'hF, 32'h11223344, 32'h0));
        vecs.push_back(mk(0, 32'h18,   1, 4'h0, 32'hAABBCCDD, 32'h0));
        vecs.push_back(mk(0, 32'h18,   0, 4'hF, 32'h0,        32'h11223344));
        vecs.push_back(mk(0, 32'h4,    1, 4'hF, 32'd55,       32'h0));
        vecs.push_back(mk(0, 32'h4,    0, 4'hF, 32'h0,        32'd55));
        vecs.push_back(mk(0, 32'h13,   0, 4'hF, 32'h0,        32'hCAFEBABE));
        vecs.push_back(mk(0, 32'h1000, 1, 4'hF, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 32'h1000, 0, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk(1, 32'h24,   1, 4'hF, 32'hA5A55A5A, 32'h0));
        vecs.push_back(mk(1, 32'h24,   0, 4'hF, 32'h0,        32'hA5A55A5A));
        vecs.push_back(mk(1, 32'h2000, 0, 4'hF, 32'h0,        32'h0));

        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt0",    32'(bus0.data_gnt_o),    32'h0);
        check("rst_rvalid0", 32'(bus0.data_rvalid_o), 32'h0);
        check("rst_rdata0",  bus0.data_rdata_o,       32'h0);
        check("rst_done0",   32'(done0),              32'h0);
        check("rst_result0", result0,                 32'h0);
        check("rst_err0",    32'(err0),               32'h0);
        check("rst_rvalid3", 32'(bus3.data_rvalid_o), 32'h0);
        check("rst_err3",    32'(err3),               32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            xact(vecs[i].sel, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, lat, rv, rd);
            check($sformatf("vec%0d_lat", i),    32'(lat), vecs[i].sel ? 32'd3 : 32'd0);
            check($sformatf("vec%0d_rvalid", i), 32'(rv),  32'h1);
            check($sformatf("vec%0d_rdata", i),  rd,       vecs[i].exp_rdata);
        end

        check("err0_sticky", 32'(err0),  32'h1);
        check("err3_set",    32'(err3),  32'h1);
        check("result0",     result0,    32'd55);
        check("done0_low",   32'(done0), 32'h0);

        // Flag write: done_o lags the grant edge by one cycle.
        @(negedge clk);
        drive(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h1);
        #1;
        check("flag_gnt", 32'(bus0.data_gnt_o), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("done_lag", 32'(done0), 32'h0);
        @(posedge clk);
        #1;
        check("done_rise", 32'(done0), 32'h1);
        check("result_hold", result0, 32'd55);

        // Back-to-back write then read of the same word.
        @(negedge clk);
        drive(0, 1'b1, 32'h20, 1'b1, 4'hF, 32'h12345678);
        #1;
        check("b2b_wr_gnt", 32'(bus0.data_gnt_o), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
        #1;
        check("b2b_rd_gnt",    32'(bus0.data_gnt_o),    32'h1);
        check("b2b_wr_rvalid", 32'(bus0.data_rvalid_o), 32'h1);
        check("b2b_wr_rdata",  bus0.data_rdata_o,       32'h0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("b2b_rd_rvalid", 32'(bus0.data_rvalid_o), 32'h1);
        check("b2b_rd_rdata",  bus0.data_rdata_o,       32'h12345678);
        @(posedge clk);
        #1;
        check("b2b_rvalid_end", 32'(bus0.data_rvalid_o), 32'h0);

        // Stalled write abandoned when req drops during STALL.
        @(negedge clk);
        drive(1, 1'b1, 32'h24, 1'b1, 4'hF, 32'h0BADF00D);
        #1;
        check("drop_gnt_idle", 32'(bus3.data_gnt_o), 32'h0);
        @(negedge clk);
        #1;
        check("drop_gnt_stall", 32'(bus3.data_gnt_o), 32'h0);
        drive(1, 1'b0, 32'h24, 1'b0, 4'h0, 32'h0);
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus3.data_gnt_o || bus3.data_rvalid_o) hits++;
        end
        check("drop_no_hs", 32'(hits), 32'h0);
        xact(1, 32'h24, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        check("drop_rd_lat",   32'(lat), 32'd3);
        check("drop_rd_rdata", rd,       32'hA5A55A5A);

        // Reset while the response is pending.
        @(negedge clk);
        drive(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
        #1;
        check("rst_mid_gnt", 32'(bus0.data_gnt_o), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("rst_mid_pre_rvalid", 32'(bus0.data_rvalid_o), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(bus0.data_rvalid_o), 32'h0);
        check("rst_mid_done",   32'(done0),              32'h0);
        check("rst_mid_result", result0,                 32'h0);
        check("rst_mid_err",    32'(err0),               32'h0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus0.data_rvalid_o) hits++;
        end
        check("rst_mid_no_rvalid", 32'(hits), 32'h0);
        xact(0, 32'h10, 1'b0, 4'hF, 32'h0, lat, rv, rd);
        check("post_rst_lat",   32'(lat), 32'd0);
        check("post_rst_rdata", rd,       32'hCAFEBABE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_data_mem.md
Name: soc_data_mem

Overview:
- Data-side memory slave for the single-core SoC; sits directly downstream of the core's data port and consumes its req/gnt/rvalid transactions.
- Provides word-addressed RAM with byte enables and a configurable stall for handshake stress.
- Words 0 and 1 are dedicated reset-able registers (completion flag, result), exported as `done_o` and `result_o` for benches and the SoC top.

Parameters:
- ADDR_WIDTH, 32: width of `data_addr_i` (byte address).
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, ≥4.
- WAIT_CYCLES, 0: stall cycles between `req` seen and `gnt` asserted (0..15).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_req_i  in  1  core request; held with addr/we/be/wdata stable until gnt.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid, exactly one cycle per granted request.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables, bit n covers wdata[8n+7:8n].
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data, valid with rvalid.
- done_o  out  1  registered; high while word 0 != 0.
- result_o  out  32  contents of word 1.
- err_o  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (async, rst_i=1): FSM→IDLE, stall counter=0, data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, word0=0, word1=0, done_o=0, result_o=0, err_o=0. RAM words ≥2 are not reset.
- Word index = data_addr_i[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored. Out of range = any addr bit above the index field set.
- FSM states: IDLE, STALL, RESP.
- IDLE, WAIT_CYCLES=0: data_gnt_o = data_req_i (combinational). On gnt, the access is performed at that clock edge; go to RESP.
- IDLE, WAIT_CYCLES>0: on req, load counter=WAIT_CYCLES−1; go to STALL; gnt=0.
- STALL: counter decrements each cycle. At counter=0, data_gnt_o=1 if req is still high; access performed; go to RESP. If req drops in STALL (protocol violation), return to IDLE, no access, no rvalid.
- RESP: data_rvalid_o=1 for exactly one cycle.
  - Reads: data_rdata_o = captured word.
  - Writes: data_rdata_o = 0.
  - With WAIT_CYCLES=0, a new req is granted in the same RESP cycle (back-to-back: one transaction per cycle, read latency 1). Otherwise go to IDLE.
- Write: only bytes with be=1 are updated; be=0000 is a legal no-op that still responds.
- Read-after-write to the same word in consecutive transactions returns the new data; no hazard.
- Out of range: write dropped; read returns 32'h0; err_o set and held until reset. Handshake completes normally.
- done_o, result_o are registered copies updated the cycle after a write to word 0/1; visible one cycle after the write's gnt edge.
- Reset asserted mid-transaction: pending grant/response is abandoned; no rvalid after reset releases.

Decomposition:
- Shared package soc_mem_pkg:
  - FLAG_WORD=0, RESULT_WORD=1
  - mem_state_e {IDLE, STALL, RESP}
  - function apply_be(old, wdata, be)
- One sub-module: soc_sram_be, a DEPTH_WORDS×32 synchronous RAM with byte-write enables and no reset. Flag/result registers and the FSM live in soc_data_mem.

Test Plan:
- WAIT=0: write 0xCAFEBABE to addr 0x10 with be=1111, then read 0x10.
  - Response: gnt in the same cycle as each req; rvalid one cycle after gnt; rdata=0xCAFEBABE.
- Byte enables: write 0xFFFFFFFF, then 0x00000000 with be=0101, read back → 0xFF00FF00.
- WAIT=3: single read.
  - Response: gnt exactly 3 cycles after req rises; rvalid on the next cycle.
  - Drop req during STALL: no gnt, no rvalid.
- Completion: write 55 to addr 0x4, then 1 to addr 0x0 → result_o=55; done_o rises one cycle after the flag write's gnt edge.
- Out of range: write to addr 4·DEPTH_WORDS, then read it back.
  - Response: both handshakes complete; read rdata=0; err_o=1 and stays 1.
- Async reset: assert rst_i in the cycle between gnt and rvalid.
  - Response: rvalid stays 0; done_o=0, result_o=0, err_o=0 immediately, without waiting for a clock edge.
